// File: rtl/adc_sequencer.sv
// Multiplexed-ADC sweep sequencer with Wishbone control/status registers.
// Optional: define ADC_SEQ_AVG_EN to convert every enabled channel four times and report the truncated mean.
`timescale 1ns/1ps
module adc_sequencer #(
    parameter int NUM_CHANS     = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int CONV_TIMEOUT  = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [4:0]  adc_mux_sel,
    output logic        adc_start,
    input  logic        adc_done,
    input  logic [11:0] adc_data,
    output logic        adc_strb,
    output logic [4:0]  adc_channel,
    output logic [11:0] adc_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONV,
        S_EMIT,
        S_WAIT
    } state_t;

    localparam logic [4:0]  LAST_CHAN   = 5'(NUM_CHANS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CONV_LAST   = 16'(CONV_TIMEOUT - 1);

    state_t      r_state;
    logic [4:0]  r_chan;
    logic [15:0] r_cnt;
    logic [31:0] r_mask_sh;
    logic [15:0] r_period_sh;
    logic [4:0]  r_mux_sel;
    logic        r_adc_start;
    logic        r_adc_strb;
    logic [4:0]  r_adc_channel;
    logic [11:0] r_adc_result;

    logic        r_enable;
    logic        r_oneshot;
    logic [31:0] r_mask;
    logic [15:0] r_period;
    logic [14:0] r_sweep_cnt;
    logic [15:0] r_timeout_cnt;
    logic        r_ack;
    logic [15:0] r_dat_o;

    logic        w_wb_access;
    logic        w_wb_write;
    logic        w_busy;
    logic        w_sweep_end;
    logic        w_timeout;
    logic        w_conv_fin;
    logic [11:0] w_conv_val;
    logic        w_begin_sweep;
    logic [4:0]  w_next_chan;
    logic [15:0] w_rd_data;

`ifdef ADC_SEQ_AVG_EN
    logic [13:0] r_sum;
    logic [1:0]  r_avg_idx;
    logic [13:0] w_sum_next;

    assign w_sum_next = r_sum + {2'b00, adc_data};
    assign w_conv_fin = (adc_done && (r_avg_idx == 2'd3)) || w_timeout;
    assign w_conv_val = w_timeout ? 12'hFFF : w_sum_next[13:2];
`else
    assign w_conv_fin = adc_done || w_timeout;
    assign w_conv_val = adc_done ? adc_data : 12'hFFF;
`endif

    assign w_wb_access = wb_cyc_i && wb_stb_i && !r_ack;
    assign w_wb_write  = w_wb_access && wb_we_i;
    assign w_busy      = (r_state != S_IDLE);
    assign w_sweep_end = (r_state == S_EMIT) && (r_chan == LAST_CHAN);
    assign w_timeout   = (r_state == S_CONV) && !adc_done && (r_cnt == CONV_LAST);
    assign w_next_chan = r_chan + 5'd1;

    // A new sweep starts from IDLE, after the inter-sweep wait, or straight from the last beat when PERIOD is 0.
    assign w_begin_sweep = ((r_state == S_IDLE) && (r_enable || r_oneshot))
                        || ((r_state == S_WAIT) && r_enable && (r_cnt >= r_period_sh))
                        || (w_sweep_end && r_enable && (r_period_sh == 16'd0));

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves w_rd_data unassigned (no latch).
        w_rd_data = 16'h0000;
        case (wb_adr_i)
            16'd0:   w_rd_data = {14'h0000, r_oneshot, r_enable};
            16'd1:   w_rd_data = r_mask[15:0];
            16'd2:   w_rd_data = r_mask[31:16];
            16'd3:   w_rd_data = r_period;
            16'd4:   w_rd_data = {r_sweep_cnt, w_busy};
            16'd5:   w_rd_data = r_timeout_cnt;
            default: w_rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack         <= 1'b0;
            r_dat_o       <= '0;
            r_enable      <= 1'b0;
            r_oneshot     <= 1'b0;
            r_mask        <= '1;
            r_period      <= '0;
            r_sweep_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            r_ack <= w_wb_access;
            if (w_wb_access) r_dat_o <= w_rd_data;
            if (w_wb_write) begin
                case (wb_adr_i)
                    16'd0: begin
                        r_enable  <= wb_dat_i[0];
                        r_oneshot <= wb_dat_i[1];
                    end
                    16'd1:   r_mask[15:0]  <= wb_dat_i;
                    16'd2:   r_mask[31:16] <= wb_dat_i;
                    16'd3:   r_period      <= wb_dat_i;
                    default: ;
                endcase
            end
            if (w_sweep_end) begin
                r_oneshot   <= 1'b0;
                r_sweep_cnt <= r_sweep_cnt + 15'd1;
            end
            if (w_wb_write && (wb_adr_i == 16'd5))
                r_timeout_cnt <= '0;
            else if (w_timeout && (r_timeout_cnt != 16'hFFFF))
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state       <= S_IDLE;
            r_chan        <= '0;
            r_cnt         <= '0;
            r_mask_sh     <= '1;
            r_period_sh   <= '0;
            r_mux_sel     <= '0;
            r_adc_start   <= 1'b0;
            r_adc_strb    <= 1'b0;
            r_adc_channel <= '0;
            r_adc_result  <= '0;
`ifdef ADC_SEQ_AVG_EN
            r_sum         <= '0;
            r_avg_idx     <= '0;
`endif
        end else begin
            r_adc_start <= 1'b0;
            r_adc_strb  <= 1'b0;
            case (r_state)
                S_IDLE: r_chan <= '0;
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state     <= S_CONV;
                        r_adc_start <= 1'b1;
                        r_cnt       <= '0;
`ifdef ADC_SEQ_AVG_EN
                        r_sum       <= '0;
                        r_avg_idx   <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_CONV: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_conv_fin) begin
                        r_state       <= S_EMIT;
                        r_adc_strb    <= 1'b1;
                        r_adc_channel <= r_chan;
                        r_adc_result  <= w_conv_val;
                    end
`ifdef ADC_SEQ_AVG_EN
                    else if (adc_done) begin
                        r_sum       <= w_sum_next;
                        r_avg_idx   <= r_avg_idx + 2'd1;
                        r_adc_start <= 1'b1;
                        r_cnt       <= '0;
                    end
`endif
                end
                S_EMIT: begin
                    if (r_chan == LAST_CHAN) begin
                        r_state <= r_enable ? S_WAIT : S_IDLE;
                        r_cnt   <= 16'd1;
                    end else begin
                        r_chan <= w_next_chan;
                        r_cnt  <= '0;
                        if (r_mask_sh[w_next_chan]) begin
                            r_state   <= S_SETTLE;
                            r_mux_sel <= w_next_chan;
                        end else begin
                            r_adc_strb    <= 1'b1;
                            r_adc_channel <= w_next_chan;
                            r_adc_result  <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (!r_enable) r_state <= S_IDLE;
                    else           r_cnt   <= r_cnt + 16'd1;
                end
                default: r_state <= S_IDLE;
            endcase

            // Sweep start overrides the per-state updates above; mask and period are frozen here.
            if (w_begin_sweep) begin
                r_mask_sh   <= r_mask;
                r_period_sh <= r_period;
                r_chan      <= '0;
                r_cnt       <= '0;
                if (r_mask[0]) begin
                    r_state   <= S_SETTLE;
                    r_mux_sel <= '0;
                end else begin
                    r_state       <= S_EMIT;
                    r_adc_strb    <= 1'b1;
                    r_adc_channel <= '0;
                    r_adc_result  <= '0;
                end
            end
        end
    end

    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat_o;
    assign adc_mux_sel = r_mux_sel;
    assign adc_start   = r_adc_start;
    assign adc_strb    = r_adc_strb;
    assign adc_channel = r_adc_channel;
    assign adc_result  = r_adc_result;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed testbench for adc_sequencer: ADC model with fixed 3-cycle conversion, strobe/start logger.
`timescale 1ns/1ps
module tb_adc_sequencer;

`ifdef ADC_SEQ_AVG_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [15:0] wb_adr = '0;
    logic [15:0] wb_wdat = '0;
    logic [15:0] wb_rdat;
    logic        wb_ack;
    logic [4:0]  adc_mux_sel;
    logic        adc_start;
    logic        adc_done = 1'b0;
    logic [11:0] adc_data = '0;
    logic        adc_strb;
    logic [4:0]  adc_channel;
    logic [11:0] adc_result;

    int n_cmp = 0;
    int n_err = 0;

    adc_sequencer dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb_cyc_i    (wb_cyc),
        .wb_stb_i    (wb_stb),
        .wb_we_i     (wb_we),
        .wb_adr_i    (wb_adr),
        .wb_dat_i    (wb_wdat),
        .wb_dat_o    (wb_rdat),
        .wb_ack_o    (wb_ack),
        .adc_mux_sel (adc_mux_sel),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .adc_strb    (adc_strb),
        .adc_channel (adc_channel),
        .adc_result  (adc_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ADC model: done three negedges after seeing start; mode 1 returns 10,11,12,... per conversion.
    int model_dly = 0;
    int hang_ch = -1;
    int model_mode = 0;
    int avg_k = 0;
    always @(negedge clk) begin
        adc_done = 1'b0;
        if (!rst_n) begin
            model_dly = 0;
        end else begin
            if (model_dly > 0) begin
                model_dly--;
                if (model_dly == 0) begin
                    adc_done = 1'b1;
                    if (model_mode == 1) begin
                        adc_data = 12'(10 + avg_k);
                        avg_k++;
                    end else begin
                        adc_data = 12'h100 + 12'(adc_mux_sel);
                    end
                end
            end
            if (adc_start && (int'(adc_mux_sel) != hang_ch)) model_dly = 3;
        end
    end

    int strb_t[$];
    int strb_ch[$];
    int strb_res[$];
    int start_t[$];
    int start_mux[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (adc_strb) begin
                strb_t.push_back(cyc);
                strb_ch.push_back(int'(adc_channel));
                strb_res.push_back(int'(adc_result));
            end
            if (adc_start) begin
                start_t.push_back(cyc);
                start_mux.push_back(int'(adc_mux_sel));
            end
        end
    end

    task automatic clear_log();
        strb_t.delete();
        strb_ch.delete();
        strb_res.delete();
        start_t.delete();
        start_mux.delete();
    endtask

    task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] wdat,
                           output logic [15:0] rdat);
        int k = 0;
        @(posedge clk);
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_wdat = wdat;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!wb_ack && k < 8);
        rdat = wb_rdat;
        if (!wb_ack) begin
            n_cmp++; n_err++;
            $display("FAIL wb_ack_timeout adr=%0d: got no ack, expected ack within 8 cycles", adr);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic [15:0] adr, input logic [15:0] wdat);
        logic [15:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic wb_read(input logic [15:0] adr, output logic [15:0] rdat);
        wb_xfer(1'b0, adr, 16'h0000, rdat);
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (strb_t.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        if (strb_t.size() < n) begin
            n_err++;
            $display("FAIL %s_wait: got %0d strobes, expected %0d", tag, strb_t.size(), n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        hang_ch = -1; model_mode = 0; avg_k = 0;
        repeat (3) @(posedge clk);
        clear_log();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic [15:0] exp_v [7] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({adc_mux_sel, adc_start, adc_strb, adc_channel, adc_result, wb_ack, wb_rdat} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %0h, expected 0",
                     {adc_mux_sel, adc_start, adc_strb, adc_channel, adc_result, wb_ack, wb_rdat});
        end
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wb_read(16'(i), d);
            n_cmp++;
            if (d !== exp_v[i]) begin
                n_err++;
                $display("FAIL reset_reg%0d: got %h, expected %h", i, d, exp_v[i]);
            end
        end
        wb_write(16'd7, 16'h1234);
        wb_read(16'd7, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL unmapped_read: got %h, expected 0000", d);
        end
    endtask

    task automatic test_wb_handshake();
        logic [3:0] acks;
        logic [15:0] d0;
        @(posedge clk);
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 16'd1;
        d0 = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            acks[3-i] = wb_ack;
            if (i == 0) d0 = wb_rdat;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        n_cmp++;
        if (acks !== 4'b1010) begin
            n_err++;
            $display("FAIL ack_pattern: got %b, expected 1010", acks);
        end
        n_cmp++;
        if (d0 !== 16'hFFFF) begin
            n_err++;
            $display("FAIL held_read_data: got %h, expected ffff", d0);
        end
    endtask

    task automatic test_full_sweep();
        logic [15:0] d;
        int bad = 0;
        do_reset();
        wb_write(16'd0, 16'h0001);
        wait_strobes(33, 3000, "full_sweep");
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (strb_ch[i] !== i || strb_res[i] !== 'h100 + i) begin
                n_err++;
                $display("FAIL sweep_beat%0d: got ch=%0d res=%h, expected ch=%0d res=%h",
                         i, strb_ch[i], strb_res[i], i, 'h100 + i);
            end
        end
        n_cmp++;
        if (strb_ch[32] !== 0 || strb_res[32] !== 'h100) begin
            n_err++;
            $display("FAIL second_sweep_start: got ch=%0d res=%h, expected ch=0 res=100", strb_ch[32], strb_res[32]);
        end
        n_cmp++;
        if (strb_t[0] - start_t[NCONV-1] !== 4) begin
            n_err++;
            $display("FAIL start_to_strobe: got %0d, expected 4", strb_t[0] - start_t[NCONV-1]);
        end
        n_cmp++;
        if (start_t[NCONV] - strb_t[0] !== 17 || start_mux[NCONV] !== 1) begin
            n_err++;
            $display("FAIL settle_time: got %0d mux=%0d, expected 17 mux=1", start_t[NCONV] - strb_t[0], start_mux[NCONV]);
        end
        wb_read(16'd4, d);
        n_cmp++;
        if (d !== 16'h0003) begin
            n_err++;
            $display("FAIL status_after_sweep: got %h, expected 0003", d);
        end
        bad = 0;
    endtask

    task automatic test_oneshot_mask();
        logic [15:0] d;
        int exp_res;
        do_reset();
        wb_write(16'd1, 16'h0005);
        wb_write(16'd2, 16'h0000);
        clear_log();
        wb_write(16'd0, 16'h0002);
        wait_strobes(32, 2000, "oneshot");
        repeat (50) @(posedge clk);
        n_cmp++;
        if (strb_t.size() !== 32 || start_t.size() !== 2 * NCONV) begin
            n_err++;
            $display("FAIL oneshot_counts: got strobes=%0d starts=%0d, expected 32 and %0d",
                     strb_t.size(), start_t.size(), 2 * NCONV);
        end
        n_cmp++;
        if (start_mux[0] !== 0 || start_mux[NCONV] !== 2) begin
            n_err++;
            $display("FAIL oneshot_start_mux: got %0d,%0d, expected 0,2", start_mux[0], start_mux[NCONV]);
        end
        for (int i = 0; i < 32; i++) begin
            exp_res = (i == 0 || i == 2) ? 'h100 + i : 0;
            n_cmp++;
            if (strb_ch[i] !== i || strb_res[i] !== exp_res) begin
                n_err++;
                $display("FAIL masked_beat%0d: got ch=%0d res=%h, expected ch=%0d res=%h",
                         i, strb_ch[i], strb_res[i], i, exp_res);
            end
        end
        wb_read(16'd0, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL oneshot_selfclear: got %h, expected 0000", d);
        end
        wb_read(16'd4, d);
        n_cmp++;
        if (d !== 16'h0002) begin
            n_err++;
            $display("FAIL oneshot_idle_status: got %h, expected 0002", d);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] d;
        do_reset();
        hang_ch = 7;
        wb_write(16'd0, 16'h0002);
        wait_strobes(32, 3000, "timeout");
        n_cmp++;
        if (strb_ch[7] !== 7 || strb_res[7] !== 'hFFF) begin
            n_err++;
            $display("FAIL timeout_result: got ch=%0d res=%h, expected ch=7 res=fff", strb_ch[7], strb_res[7]);
        end
        n_cmp++;
        if (strb_t[7] - start_t[7*NCONV] !== 255) begin
            n_err++;
            $display("FAIL timeout_delay: got %0d, expected 255", strb_t[7] - start_t[7*NCONV]);
        end
        n_cmp++;
        if (strb_ch[31] !== 31 || strb_res[31] !== 'h11F) begin
            n_err++;
            $display("FAIL timeout_continue: got ch=%0d res=%h, expected ch=31 res=11f", strb_ch[31], strb_res[31]);
        end
        wb_read(16'd5, d);
        n_cmp++;
        if (d !== 16'h0001) begin
            n_err++;
            $display("FAIL timeout_cnt: got %h, expected 0001", d);
        end
        wb_write(16'd5, 16'hABCD);
        wb_read(16'd5, d);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_err++;
            $display("FAIL timeout_cnt_clear: got %h, expected 0000", d);
        end
    endtask

    task automatic test_disable_and_reset();
        logic [15:0] d;
        int order_bad;
        do_reset();
        wb_write(16'd0, 16'h0001);
        wait_strobes(11, 2000, "reach_ch10");
        wb_write(16'd0, 16'h0000);
        wait_strobes(32, 2000, "finish_sweep");
        repeat (1000) @(posedge clk);
        n_cmp++;
        if (strb_t.size() !== 32) begin
            n_err++;
            $display("FAIL disable_strobe_count: got %0d, expected 32", strb_t.size());
        end
        order_bad = 0;
        for (int i = 0; i < 32; i++) if (strb_ch[i] !== i) order_bad++;
        n_cmp++;
        if (order_bad !== 0) begin
            n_err++;
            $display("FAIL disable_order: got %0d out-of-order beats, expected 0", order_bad);
        end
        wb_read(16'd4, d);
        n_cmp++;
        if (d !== 16'h0002) begin
            n_err++;
            $display("FAIL disable_status: got %h, expected 0002", d);
        end
        clear_log();
        wb_write(16'd0, 16'h0001);
        wait_strobes(6, 2000, "reach_ch5");
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({adc_mux_sel, adc_start, adc_strb, adc_channel, adc_result, wb_ack} !== '0) begin
            n_err++;
            $display("FAIL midsweep_reset_outputs: got %0h, expected 0",
                     {adc_mux_sel, adc_start, adc_strb, adc_channel, adc_result, wb_ack});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(posedge clk);
        n_cmp++;
        if (strb_t.size() !== 6) begin
            n_err++;
            $display("FAIL midsweep_reset_strobes: got %0d, expected 6", strb_t.size());
        end
    endtask

    task automatic test_period_mask();
        int exp_res;
        do_reset();
        wb_write(16'd3, 16'd100);
        wb_write(16'd0, 16'h0001);
        wait_strobes(3, 2000, "reach_ch2");
        wb_write(16'd1, 16'h0001);
        wb_write(16'd2, 16'h0000);
        wait_strobes(64, 4000, "two_sweeps");
        for (int i = 0; i < 64; i++) begin
            exp_res = (i < 32) ? 'h100 + i : ((i == 32) ? 'h100 : 0);
            n_cmp++;
            if (strb_ch[i] !== (i % 32) || strb_res[i] !== exp_res) begin
                n_err++;
                $display("FAIL period_beat%0d: got ch=%0d res=%h, expected ch=%0d res=%h",
                         i, strb_ch[i], strb_res[i], i % 32, exp_res);
            end
        end
        n_cmp++;
        if (start_t[32*NCONV] - strb_t[31] !== 117 || start_mux[32*NCONV] !== 0) begin
            n_err++;
            $display("FAIL period_gap: got %0d mux=%0d, expected 117 mux=0",
                     start_t[32*NCONV] - strb_t[31], start_mux[32*NCONV]);
        end
        n_cmp++;
        if (start_t.size() !== 33 * NCONV) begin
            n_err++;
            $display("FAIL new_mask_starts: got %0d, expected %0d", start_t.size(), 33 * NCONV);
        end
        n_cmp++;
        if (strb_t[63] - strb_t[33] !== 30 || strb_t[33] - strb_t[32] !== 1) begin
            n_err++;
            $display("FAIL masked_back_to_back: got %0d/%0d, expected 30/1",
                     strb_t[63] - strb_t[33], strb_t[33] - strb_t[32]);
        end
        wb_write(16'd0, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int nz;
        do_reset();
        wb_write(16'd1, 16'h0000);
        wb_write(16'd2, 16'h0000);
        clear_log();
        wb_write(16'd0, 16'h0002);
        wait_strobes(32, 500, "all_masked");
        repeat (20) @(posedge clk);
        n_cmp++;
        if (start_t.size() !== 0 || strb_t.size() !== 32) begin
            n_err++;
            $display("FAIL all_masked_counts: got starts=%0d strobes=%0d, expected 0 and 32",
                     start_t.size(), strb_t.size());
        end
        n_cmp++;
        if (strb_t[31] - strb_t[0] !== 31) begin
            n_err++;
            $display("FAIL all_masked_span: got %0d, expected 31", strb_t[31] - strb_t[0]);
        end
        nz = 0;
        for (int i = 0; i < 32; i++) if (strb_res[i] !== 0 || strb_ch[i] !== i) nz++;
        n_cmp++;
        if (nz !== 0) begin
            n_err++;
            $display("FAIL all_masked_values: got %0d bad beats, expected 0", nz);
        end
    endtask

`ifdef ADC_SEQ_AVG_EN
    task automatic test_avg();
        do_reset();
        model_mode = 1;
        wb_write(16'd1, 16'h0001);
        wb_write(16'd2, 16'h0000);
        clear_log();
        wb_write(16'd0, 16'h0002);
        wait_strobes(32, 1000, "avg");
        n_cmp++;
        if (start_t.size() !== 4) begin
            n_err++;
            $display("FAIL avg_starts: got %0d, expected 4", start_t.size());
        end
        n_cmp++;
        if (strb_ch[0] !== 0 || strb_res[0] !== 11 || strb_res[1] !== 0) begin
            n_err++;
            $display("FAIL avg_result: got ch=%0d res=%0d next=%0d, expected ch=0 res=11 next=0",
                     strb_ch[0], strb_res[0], strb_res[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wb_handshake();
        test_full_sweep();
        test_oneshot_mask();
        test_timeout();
        test_disable_and_reset();
        test_period_mask();
        test_back_to_back();
`ifdef ADC_SEQ_AVG_EN
        test_avg();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
